// File: rtl/unary_vector_decoder.sv
// Counts DIM framed signed unary pulse streams and presents binary lane sums on a valid/ready register.
// Optional macro UNARY_DEC_SAT_EN: per-lane saturation plus a sticky out_sat flag per frame.
module unary_vector_decoder #(
  parameter int unsigned DIM     = 16,
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned OWIDTH  = 2*WIDTH+1,
  parameter int unsigned MAX_LEN = 2**(2*WIDTH)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic                          last,
  input  logic [DIM-1:0]                unary_in,
  input  logic [DIM-1:0]                neg_in,
  output logic                          in_ready,
  output logic [DIM-1:0][OWIDTH-1:0]    out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_timeout,
`ifdef UNARY_DEC_SAT_EN
  output logic [DIM-1:0]                out_sat,
`endif
  output logic                          busy
);

  localparam int unsigned CW = $clog2(MAX_LEN + 1);
  localparam logic [OWIDTH-1:0] ONE  = OWIDTH'(1);
`ifdef UNARY_DEC_SAT_EN
  localparam logic [OWIDTH-1:0] MAXV = {1'b0, {(OWIDTH-1){1'b1}}};
  localparam logic [OWIDTH-1:0] MINV = {1'b1, {(OWIDTH-1){1'b0}}};
`endif

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                         r_state;
  logic [CW-1:0]                  r_cnt;
  logic [DIM-1:0][OWIDTH-1:0]     r_acc;
  logic [DIM-1:0][OWIDTH-1:0]     r_out_data;
  logic                           r_out_valid;
  logic                           r_out_timeout;

  logic                           w_active;
  logic                           w_close;
  logic                           w_timeout;
  logic [CW-1:0]                  w_cnt_next;
  logic [OWIDTH-1:0]              w_base;
  logic [DIM-1:0][OWIDTH-1:0]     w_sum;

`ifdef UNARY_DEC_SAT_EN
  logic [DIM-1:0]                 r_sat;
  logic [DIM-1:0]                 r_out_sat;
  logic [DIM-1:0]                 w_sat_next;
`endif

  assign in_ready    = ~r_out_valid | out_ready;
  assign busy        = (r_state == ACCUM);
  assign out_data    = r_out_data;
  assign out_valid   = r_out_valid;
  assign out_timeout = r_out_timeout;
`ifdef UNARY_DEC_SAT_EN
  assign out_sat     = r_out_sat;
`endif

  // A start always opens a fresh frame (aborting any open one); otherwise only ACCUM counts.
  assign w_active   = in_ready & (start | (r_state == ACCUM));
  assign w_cnt_next = start ? CW'(1) : (r_cnt + CW'(1));
  assign w_close    = w_active & (last | (w_cnt_next == CW'(MAX_LEN)));
  assign w_timeout  = w_close & ~last;

  // Per-lane next sum including this cycle's contribution.
  always_comb begin
    w_base = '0;
    w_sum  = '0;
`ifdef UNARY_DEC_SAT_EN
    w_sat_next = '0;
`endif
    for (int l = 0; l < DIM; l++) begin
      w_base   = start ? '0 : r_acc[l];
      w_sum[l] = w_base;
`ifdef UNARY_DEC_SAT_EN
      w_sat_next[l] = start ? 1'b0 : r_sat[l];
      if (unary_in[l]) begin
        if (neg_in[l]) begin
          if (w_base == MINV) w_sat_next[l] = 1'b1;
          else                w_sum[l]      = w_base - ONE;
        end else begin
          if (w_base == MAXV) w_sat_next[l] = 1'b1;
          else                w_sum[l]      = w_base + ONE;
        end
      end
`else
      if (unary_in[l]) begin
        w_sum[l] = neg_in[l] ? (w_base - ONE) : (w_base + ONE);
      end
`endif
    end
  end

  // Frame FSM, accumulators and output register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_acc         <= '0;
      r_out_data    <= '0;
      r_out_valid   <= 1'b0;
      r_out_timeout <= 1'b0;
`ifdef UNARY_DEC_SAT_EN
      r_sat         <= '0;
      r_out_sat     <= '0;
`endif
    end else begin
      if (r_out_valid & out_ready) begin
        r_out_valid   <= 1'b0;
        r_out_timeout <= 1'b0;
      end
      if (w_active) begin
        if (w_close) begin
          r_state       <= IDLE;
          r_cnt         <= '0;
          r_acc         <= '0;
          r_out_data    <= w_sum;
          r_out_valid   <= 1'b1;
          r_out_timeout <= w_timeout;
`ifdef UNARY_DEC_SAT_EN
          r_sat         <= '0;
          r_out_sat     <= w_sat_next;
`endif
        end else begin
          r_state <= ACCUM;
          r_cnt   <= w_cnt_next;
          r_acc   <= w_sum;
`ifdef UNARY_DEC_SAT_EN
          r_sat   <= w_sat_next;
`endif
        end
      end
    end
  end

endmodule

// File: doc/unary_vector_decoder.md
Name: unary_vector_decoder

Overview:
- Converts DIM parallel signed unary pulse streams back to a DIM-lane binary vector; the inverse of the binary-to-unary counter arrays feeding the unary matrix multiplier.
- Each lane counts +1/-1 pulses over a framed window (start..last), then presents the signed result on a valid/ready output register.
- Sits after unary datapaths, e.g., unary results leaving the multiplier core, to hand binary vectors to downstream logic.

Parameters:
- DIM, 16, number of lanes.
- WIDTH, 4, source magnitude width; sets the nominal frame length 2**WIDTH.
- OWIDTH, 2*WIDTH+1, signed two's-complement width of each lane result.
- MAX_LEN, 2**(2*WIDTH), maximum accepted cycles per frame before forced close.

Ports:
- clk  input  1  clock.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  first cycle of a frame; this cycle's pulses are counted.
- last  input  1  final cycle of a frame; this cycle's pulses are counted.
- unary_in  input  [DIM-1:0]  per-lane pulse.
- neg_in  input  [DIM-1:0]  per-lane sign: 1 means the pulse counts as -1.
- in_ready  output  1  input accepted this cycle; combinational: !out_valid | out_ready.
- out_data  output  [DIM-1:0][OWIDTH-1:0]  signed lane results.
- out_valid  output  1  out_data holds an unconsumed frame result.
- out_ready  input  1  downstream accepts out_data.
- out_timeout  output  1  the held frame was force-closed at MAX_LEN.
- busy  output  1  state==ACCUM.

Behaviour:
- Reset values: state IDLE; accumulators 0; frame counter 0; out_data 0; out_valid 0; out_timeout 0; busy 0.
- Reset is asynchronous: asserting it mid-frame discards the frame with no output.
- Input acceptance: a cycle is accepted only when in_ready=1. When in_ready=0, start, last, unary_in and neg_in are ignored and all state holds.
- Lane contribution per accepted cycle: unary_in=0 gives 0 (neg_in ignored); unary_in=1 and neg_in=0 gives +1; unary_in=1 and neg_in=1 gives -1.
- State IDLE:
  - Accepted start: acc <= contribution, cnt <= 1, go to ACCUM.
  - Accepted start with last: single-cycle frame; result = contribution; stay IDLE.
  - Pulses without start: ignored.
  - last without start: ignored.
- State ACCUM, per accepted cycle: acc <= acc + contribution, cnt <= cnt + 1.
  - start in ACCUM: aborts the current frame; acc <= contribution, cnt <= 1; no output for the aborted frame. start together with last is a single-cycle frame.
  - Close on accepted last, or on the accepted cycle where cnt reaches MAX_LEN. The result includes that cycle's contribution. Go to IDLE.
- Close action:
  - out_data <= final sums; out_valid <= 1 on the next edge.
  - out_timeout <= 1 only if the frame closed at MAX_LEN without last.
  - Latency: out_valid rises 1 cycle after the closing cycle.
- Output handshake:
  - out_valid and out_data hold stable until out_valid & out_ready.
  - On transfer, out_valid <= 0 unless a new close occurs in the same cycle; that is allowed because in_ready=1, and new data loads with out_valid staying 1.
  - Back-pressure: while out_valid & !out_ready, in_ready=0, so a frame in ACCUM stalls and no data is lost.
- Arithmetic: acc is OWIDTH-bit signed.
  - Without the optional feature, sums wrap modulo 2**OWIDTH.
  - Range check: lane |sum| <= MAX_LEN must fit or wrap; the default OWIDTH fits a full 2**WIDTH frame.

Optional Feature:
- Macro: UNARY_DEC_SAT_EN.
- Defined:
  - Each lane saturates at +(2**(OWIDTH-1)-1) and -(2**(OWIDTH-1)).
  - A per-frame sticky flag is added as extra output out_sat [DIM-1:0], registered with out_data and reset to 0.
  - Once saturated, further same-direction pulses hold the value; opposite pulses count normally.
- Undefined: two's-complement wrap; no out_sat port.

Test Plan:
- DIM=4, OWIDTH=9, MAX_LEN=256, out_ready=1. Start, then 10 cycles lane0 +1, lane1 -1, lane2 alternating +1/-1, lane3 idle, last on cycle 10 -> one cycle later out_valid=1, out_data={0,0,-10,10} (lanes 3..0), out_timeout=0.
- start&last in IDLE with unary_in=4'b1111, neg_in=4'b0101 -> out_data lanes 3..0 = {1,-1,1,-1}; busy stays 0.
- out_ready=0 while a result is held; start a second frame of 5 +1 pulses -> in_ready=0 and busy holds; raise out_ready -> first result transfers, second frame resumes, final lane value 5 with no lost pulses.
- Start, 3 pulses, then start again with 2 pulses and last -> single output of 2; no output for the aborted frame.
- MAX_LEN=8, lane0 +1 every cycle, no last -> closes after the 8th cycle; out_data[0]=8, out_timeout=1.
- With UNARY_DEC_SAT_EN, OWIDTH=4, 12 +1 pulses then last -> out_data=7, out_sat[0]=1; without the macro, the value wraps to -4.
